prince_inv_affine_serial: RTL and testbench
===========================================

PRINCE_INV_AFFINE_SERIAL -- requirements
Module: prince_inv_affine_serial

Interface
REQ-001 SHALL provide parameter NIBBLES, default 16, number of 4-bit nibbles per share (state width = 4*NIBBLES).
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL provide port start  input  1  request to process the current x1/x2/x3; sampled on rising clk.
REQ-005 SHALL provide ports x1, x2, x3  input  4*NIBBLES  input shares 1..3 of the masked state.
REQ-006 SHALL provide ports y1, y2, y3  output  4*NIBBLES  output shares 1..3 after inverse affine layer.
REQ-007 SHALL provide port busy  output  1  high while nibbles are being processed.
REQ-008 SHALL provide port done  output  1  one-cycle pulse: y1..y3 hold a complete result.

Function
REQ-009 SHALL implement states IDLE, RUN, DONE; DONE lasts exactly one cycle, then IDLE.
REQ-010 SHALL, in IDLE or DONE with start=1 at an edge, load x1/x2/x3 into three share shift registers, clear the nibble counter, enter RUN.
REQ-011 SHALL ignore start while in RUN; no reload, counter unaffected.
REQ-012 SHALL, each RUN cycle, take nibble 0 (bits 3:0) of each share register, map it, shift the register right by 4 and insert the mapped nibble at the top (bits 4*NIBBLES-1 : 4*NIBBLES-4).
REQ-013 SHALL apply the linear map L to every share nibble x: y[3]=x[0]; y[2]=x[3]^x[0]; y[1]=x[2]^x[3]; y[0]=x[1]^x[2].
REQ-014 SHALL XOR constant 4'hA after L into share 1 only; shares 2 and 3 get L only.
REQ-015 SHALL keep each share's datapath independent: no logic, register or mux combines bits of two different shares.
REQ-016 SHALL leave RUN on the edge that completes nibble NIBBLES-1 (counter wraps NIBBLES-1 -> 0) and enter DONE; processing is NIBBLES cycles, so done rises NIBBLES edges after the start edge.
REQ-017 SHALL drive busy=1 exactly in RUN; done=1 exactly in DONE; both registered.
REQ-018 SHALL drive y1..y3 directly from the share registers; values are only guaranteed in DONE and in the IDLE cycles after it, held until the next accepted start.
REQ-019 SHALL, on start in the DONE cycle, accept it per REQ-010 (back-to-back operation, no idle gap).
REQ-020 SHALL size the counter to ceil(log2(NIBBLES)) bits, minimum 1.

Reset
REQ-021 SHALL, while rst=1, force IDLE, counter=0, y1=y2=y3=0, busy=0, done=0, independent of clk.
REQ-022 SHALL, on rst assertion mid-RUN, abandon the operation; done does not pulse for it; after release the block waits in IDLE for start.

Verification
REQ-023 SHALL cover: x1=x2=x3=0, start -> done NIBBLES (16) edges after start edge; y1=64'hAAAA_AAAA_AAAA_AAAA, y2=y3=0.
REQ-024 SHALL cover: x1=64'h1111_1111_1111_1111, x2=64'h8888_8888_8888_8888, x3=64'hFFFF_FFFF_FFFF_FFFF -> y1=64'h6666_6666_6666_6666 (C^A), y2=64'h6666_6666_6666_6666, y3=64'h8888_8888_8888_8888.
REQ-025 SHALL cover: x1=64'h0000_0000_0000_0001, x2=x3=0 -> y1=64'hAAAA_AAAA_AAAA_AAA6 (nibble order kept); y2=y3=0.
REQ-026 SHALL cover: start pulsed again at RUN cycle 5 with different x -> ignored; result matches first inputs; exactly one done pulse.
REQ-027 SHALL cover: start held high through DONE -> second operation accepted in DONE cycle; busy returns to 1 next cycle; second done 16 edges later.
REQ-028 SHALL cover: rst asserted asynchronously at RUN cycle 8 -> outputs 0 immediately, no done; new start after release produces the correct result.

Source files
------------

// File: rtl/prince_inv_affine_serial.sv
// prince_inv_affine_serial
// Nibble-serial inverse affine layer for a three-share masked PRINCE state.
// Each share sits in its own shift register. On every RUN cycle the lowest
// nibble is passed through the linear map L, which is followed by XOR 4'hA
// on share 1 only, and is then reinserted at the top. After NIBBLES cycles
// every nibble is back in its original position.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      load x1..x3 and begin (accepted in IDLE or DONE)
//   x1,x2,x3   input shares, 4*NIBBLES bits each
//   y1,y2,y3   output shares, driven straight from the share registers
//   busy       high while in RUN
//   done       one-cycle pulse when y1..y3 hold a complete result
module prince_inv_affine_serial #(
  parameter int NIBBLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] x1,
  input  logic [4*NIBBLES-1:0] x2,
  input  logic [4*NIBBLES-1:0] x3,
  output logic [4*NIBBLES-1:0] y1,
  output logic [4*NIBBLES-1:0] y2,
  output logic [4*NIBBLES-1:0] y3,
  output logic                 busy,
  output logic                 done
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          r_state, w_next;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_s1, r_s2, r_s3;
  logic            r_busy, r_done;
  logic            w_load, w_last;

  function automatic logic [3:0] lmap(input logic [3:0] x);
    return {x[0], x[3] ^ x[0], x[2] ^ x[3], x[1] ^ x[2]};
  endfunction

  // Shift right by one nibble and insert the mapped nibble at the top.
  // Written as a shift/OR so that it also holds for NIBBLES == 1.
  function automatic logic [W-1:0] step(input logic [W-1:0] s, input logic [3:0] k);
    return (s >> 4) | (W'(lmap(s[3:0]) ^ k) << (W - 4));
  endfunction

  assign w_load = start && (r_state != S_RUN);
  assign w_last = (r_cnt == CW'(NIBBLES - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == S_RUN);
      r_done  <= (w_next == S_DONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_load) begin
      r_cnt <= '0;
    end else if (r_state == S_RUN) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

  // Each share has its own register and update path; no share's bits mix with another's.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else if (w_load) begin
      r_s1 <= x1;
      r_s2 <= x2;
      r_s3 <= x3;
    end else if (r_state == S_RUN) begin
      r_s1 <= step(r_s1, 4'hA);
      r_s2 <= step(r_s2, 4'h0);
      r_s3 <= step(r_s3, 4'h0);
    end
  end

  assign y1   = r_s1;
  assign y2   = r_s2;
  assign y3   = r_s3;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_prince_inv_affine_serial.sv
module tb_prince_inv_affine_serial;

  localparam int N = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [63:0]   x1 = '0, x2 = '0, x3 = '0;
  logic [63:0]   y1, y2, y3;
  logic          busy, done;

  int unsigned   n_checks = 0;
  int unsigned   n_fail   = 0;

  prince_inv_affine_serial #(.NIBBLES(N)) dut (
    .clk(clk), .rst(rst), .start(start),
    .x1(x1), .x2(x2), .x3(x3),
    .y1(y1), .y2(y2), .y3(y3),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: every nibble independently goes through L (GF(2) matrix rows)
  // and then XOR k; positions are unchanged after a full pass.
  function automatic logic [63:0] ref_share(input logic [63:0] x, input logic [3:0] k);
    logic [3:0] rows [4];
    logic [3:0] nib, o;
    logic [63:0] r;
    rows[3] = 4'b0001; rows[2] = 4'b1001; rows[1] = 4'b1100; rows[0] = 4'b0110;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      nib = x[4*i +: 4];
      for (int j = 0; j < 4; j++) o[j] = ^(nib & rows[j]);
      r[4*i +: 4] = o ^ k;
    end
    return r;
  endfunction

  // Waits up to 40 edges for done; n = edge count (0 if never seen).
  task automatic wait_done(output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin n = i; break; end
    end
  endtask

  task automatic check_result(input string tag, input logic [63:0] a, b, c);
    chk({tag, "_y1"}, y1, ref_share(a, 4'hA));
    chk({tag, "_y2"}, y2, ref_share(b, 4'h0));
    chk({tag, "_y3"}, y3, ref_share(c, 4'h0));
  endtask

  task automatic run_op(input string tag, input logic [63:0] a, b, c);
    int n;
    @(negedge clk);
    x1 = a; x2 = b; x3 = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    wait_done(n);
    chk({tag, "_lat"}, 64'(n), 64'(N));
    chk({tag, "_busy_done"}, 64'(busy), 64'd0);
    check_result(tag, a, b, c);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, 64'(done), 64'd0);
    check_result({tag, "_hold"}, a, b, c);
  endtask

  initial begin
    int n, pulses;
    logic [63:0] a, b, c;

    #2;
    chk("rst_y1", y1, '0); chk("rst_y2", y2, '0); chk("rst_y3", y3, '0);
    chk("rst_busy", 64'(busy), 0); chk("rst_done", 64'(done), 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // Directed vectors
    run_op("zero", '0, '0, '0);
    chk("zero_y1_const", y1, 64'hAAAA_AAAA_AAAA_AAAA);
    run_op("pat", 64'h1111_1111_1111_1111, 64'h8888_8888_8888_8888, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("pat_y1_const", y1, 64'h6666_6666_6666_6666);
    chk("pat_y3_const", y3, 64'h8888_8888_8888_8888);
    run_op("order", 64'h1, '0, '0);
    chk("order_y1_const", y1, 64'hAAAA_AAAA_AAAA_AAA6);

    // Random vectors
    for (int t = 0; t < 8; t++) begin
      run_op("rnd", {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
    end

    // start re-pulsed during RUN is ignored
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; c = {$urandom, $urandom};
    @(negedge clk);
    x1 = a; x2 = b; x3 = c; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    x1 = ~a; x2 = ~b; x3 = ~c; start = 1'b1;
    @(negedge clk); start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done) begin
        pulses++;
        check_result("ign", a, b, c);
      end
    end
    chk("ign_pulses", 64'(pulses), 64'd1);

    // start held through DONE: back-to-back accept
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; c = {$urandom, $urandom};
    @(negedge clk);
    x1 = a; x2 = b; x3 = c; start = 1'b1;
    @(posedge clk); #1;
    x1 = ~a; x2 = b ^ 64'h1234; x3 = c + 1;
    wait_done(n);
    chk("b2b_lat1", 64'(n), 64'(N));
    check_result("b2b_first", a, b, c);
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_busy", 64'(busy), 64'd1);
    chk("b2b_nodone", 64'(done), 64'd0);
    wait_done(n);
    chk("b2b_lat2", 64'(n), 64'(N));
    check_result("b2b_second", ~a, b ^ 64'h1234, c + 1);

    // Asynchronous reset mid-RUN
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; c = {$urandom, $urandom};
    @(negedge clk);
    x1 = a; x2 = b; x3 = c; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (8) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_y1", y1, '0); chk("arst_y2", y2, '0); chk("arst_y3", y3, '0);
    chk("arst_busy", 64'(busy), 0); chk("arst_done", 64'(done), 0);
    @(posedge clk); #2 rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    chk("arst_idle", 64'(pulses), 64'd0);
    run_op("post_rst", {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
